// File: rtl/button_pkg.sv
// Shared encodings and sizing helpers for the push-button front end.
// Used by button_conditioner and debouncer.
package button_pkg;

  localparam logic [1:0] LOW       = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int cnt_width(input int dbc, input int rdly, input int rper);
    int m;
    m = dbc;
    if (rdly > m) m = rdly;
    if (rper > m) m = rper;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Single-button conditioner: 2-flop synchronizer, counter debounce FSM,
// press pulse and (when REPEAT_EN) an auto-repeat timer while held.
module debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic raw_i,
  output logic level_o,
  output logic re_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DbLim  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DlyLim = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PerLim = CW'(REPEAT_PERIOD);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  logic [1:0]    sync_q;
  logic          sync;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rep_q, rep_d;
  logic          level_q, level_d;
  logic          re_q, re_d;
  logic          press, rpt_fire;
  logic [CW-1:0] cnt_inc, rpt_inc;

  assign sync    = sync_q[1];
  assign cnt_inc = sat_inc(cnt_q);
  assign rpt_inc = sat_inc(rpt_q);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      rpt_q   <= '0;
      rep_q   <= 1'b0;
      level_q <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press    = 1'b0;
    rpt_d    = '0;
    rep_d    = 1'b0;
    rpt_fire = 1'b0;
    unique case (state_q)
      LOW: if (sync) begin
        if (DbLim <= CW'(1)) begin
          state_d = HIGH;
          press   = 1'b1;
        end else begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HIGH: if (!sync) begin
        state_d = LOW;
        cnt_d   = '0;
      end else if (cnt_inc >= DbLim) begin
        state_d = HIGH;
        cnt_d   = '0;
        press   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
      HIGH: if (!sync) begin
        if (DbLim <= CW'(1)) begin
          state_d = LOW;
        end else begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LOW: if (sync) begin
        state_d = HIGH;
        cnt_d   = '0;
      end else if (cnt_inc >= DbLim) begin
        state_d = LOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
      default: state_d = LOW;
    endcase
    // Repeat timer only runs across cycles spent continuously in HIGH.
    if (REPEAT_EN && state_q == HIGH && state_d == HIGH) begin
      if (rpt_inc >= (rep_q ? PerLim : DlyLim)) begin
        rpt_fire = 1'b1;
        rep_d    = 1'b1;
      end else begin
        rpt_d = rpt_inc;
        rep_d = rep_q;
      end
    end
  end

  always_comb begin
    level_d = (state_d == HIGH) || (state_d == WAIT_LOW);
    re_d    = press | rpt_fire;
  end

  assign level_o = level_q;
  assign re_o    = re_q;

endmodule

// File: rtl/button_conditioner.sv
// Raw push-buttons to debounced levels and one-cycle press pulses.
// Optional auto-repeat on held buttons: define BUTTON_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS                   = 2,
  parameter int DEBOUNCE_CYCLES             = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY                = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD               = DEF_REPEAT_PERIOD,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK = 2'b01
) (
  input  logic                 clk,
  input  logic                 async_nreset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] buttons_level,
  output logic [N_BUTTONS-1:0] buttons_re
);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit RptOn = 1'b1;
`else
  localparam bit RptOn = 1'b0;
`endif

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (RptOn && REPEAT_MASK[i])
    ) u_deb (
      .clk         (clk),
      .async_nreset(async_nreset),
      .raw_i       (buttons_raw[i]),
      .level_o     (buttons_level[i]),
      .re_o        (buttons_re[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Repeat expectations follow BUTTON_AUTOREPEAT_EN when it is defined.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [1:0] RPT_MASK = 2'b01;
`else
  localparam logic [1:0] RPT_MASK = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [1:0] buttons_raw = 2'b00;
  logic [1:0] buttons_level;
  logic [1:0] buttons_re;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .N_BUTTONS      (2),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (2'b01)
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .buttons_raw  (buttons_raw),
    .buttons_level(buttons_level),
    .buttons_re   (buttons_re)
  );

  always #5 clk = ~clk;

  // Reference: stable level flips after D consecutive disagreeing samples of
  // the raw input delayed by two edges; repeats counted as time since entering HIGH.
  logic [1:0] m_lvl = '0, m_re = '0, h1 = '0, h2 = '0;
  int run [2] = '{0, 0};
  int since [2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk or negedge async_nreset);
      if (!async_nreset) begin
        m_lvl = '0; m_re = '0; h1 = '0; h2 = '0;
        for (int b = 0; b < 2; b++) begin run[b] = 0; since[b] = 0; end
      end else begin
        for (int b = 0; b < 2; b++) begin
          m_re[b] = 1'b0;
          if (h2[b] != m_lvl[b]) begin
            run[b]++;
            since[b] = 0;
            if (run[b] == D) begin
              m_lvl[b] = h2[b];
              run[b] = 0;
              if (h2[b]) m_re[b] = 1'b1;
            end
          end else if (run[b] != 0) begin
            run[b] = 0;
            since[b] = 0;
          end else if (m_lvl[b] && RPT_MASK[b]) begin
            since[b]++;
            if (since[b] == RD || (since[b] > RD && (since[b] - RD) % RP == 0))
              m_re[b] = 1'b1;
          end
        end
        h2 = h1;
        h1 = buttons_raw;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    async_nreset = 1'b0;
    buttons_raw  = 2'b00;
    #1;
    chk("reset_level", {30'd0, buttons_level}, 32'd0);
    chk("reset_re", {30'd0, buttons_re}, 32'd0);
    tick(); tick(); tick();
    async_nreset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    int         exp_p0;
    int         exp_p1;
    logic [1:0] exp_lvl;
  } vec_t;

  vec_t vecs [10];
  int   p0, p1;
  int   pulse_q[$];
  int   exp_q[$];
  int   n;
  logic [1:0] flip;

  initial begin
    vecs[0] = '{2'b00, 10, 0, 0, 2'b00};
    vecs[1] = '{2'b01, 10, 1, 0, 2'b01};
    vecs[2] = '{2'b00, 10, 0, 0, 2'b00};
    vecs[3] = '{2'b11, 10, 1, 1, 2'b11};
    vecs[4] = '{2'b10, 10, 0, 0, 2'b10};
    vecs[5] = '{2'b00,  3, 0, 0, 2'b10};
    vecs[6] = '{2'b10, 10, 0, 0, 2'b10};
    vecs[7] = '{2'b11,  2, 0, 0, 2'b10};
    vecs[8] = '{2'b10, 10, 0, 0, 2'b10};
    vecs[9] = '{2'b00, 10, 0, 0, 2'b00};

    // Clean press and release
    do_reset();
    buttons_raw = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("press_re", {31'd0, buttons_re[0]}, {31'd0, k == 6});
      chk("press_lvl", {31'd0, buttons_level[0]}, {31'd0, k >= 6});
    end
    buttons_raw = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("release_re", {31'd0, buttons_re[0]}, 32'd0);
      chk("release_lvl", {31'd0, buttons_level[0]}, {31'd0, k < 6});
    end

    // Bounce 1,0,1,0,1 then held
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      buttons_raw = (k <= 5) ? {1'b0, k[0]} : 2'b01;
      tick();
      chk("bounce_re", {31'd0, buttons_re[0]}, {31'd0, k == 10});
      chk("bounce_lvl", {31'd0, buttons_level[0]}, {31'd0, k >= 10});
    end

    // Simultaneous presses
    do_reset();
    buttons_raw = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("simul_re", {30'd0, buttons_re}, (k == 6) ? 32'd3 : 32'd0);
    end

    // Reset while HIGH drops the level without a clock edge
    buttons_raw = 2'b01;
    tick();
    chk("pre_rst_lvl", {31'd0, buttons_level[0]}, 32'd1);
    #2 async_nreset = 1'b0;
    #1 chk("async_rst_lvl", {30'd0, buttons_level}, 32'd0);
    tick(); tick();
    async_nreset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("held_rel_re", {31'd0, buttons_re[0]}, {31'd0, k == 6});
    end

    // Reset while in WAIT_HIGH, released with button still held
    do_reset();
    buttons_raw = 2'b01;
    tick(); tick(); tick(); tick();
    #2 async_nreset = 1'b0;
    #1 chk("waith_rst_re", {30'd0, buttons_re}, 32'd0);
    chk("waith_rst_lvl", {30'd0, buttons_level}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("in_rst_re", {30'd0, buttons_re}, 32'd0);
    end
    async_nreset = 1'b1;
    p0 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (buttons_re[0]) p0++;
      chk("waith_rel_re", {31'd0, buttons_re[0]}, {31'd0, k == 6});
    end
    chk("waith_rel_count", p0, 1);

    // Table-driven level/pulse records
    do_reset();
    for (int i = 0; i < 10; i++) begin
      buttons_raw = vecs[i].raw;
      p0 = 0; p1 = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        tick();
        if (buttons_re[0]) p0++;
        if (buttons_re[1]) p1++;
      end
      chk($sformatf("vec%0d_p0", i), p0, vecs[i].exp_p0);
      chk($sformatf("vec%0d_p1", i), p1, vecs[i].exp_p1);
      chk($sformatf("vec%0d_lvl", i), {30'd0, buttons_level}, {30'd0, vecs[i].exp_lvl});
    end

    // Held bit 0: repeat train when enabled, single pulse otherwise
    do_reset();
    buttons_raw = 2'b01;
    pulse_q.delete();
    exp_q.delete();
    exp_q.push_back(6);
    if (RPT_MASK[0]) for (int e = 6 + RD; e <= 37; e += RP) exp_q.push_back(e);
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (buttons_re[0]) pulse_q.push_back(k);
      if (k == 37) buttons_raw = 2'b00;
    end
    chk("rpt_count", pulse_q.size(), exp_q.size());
    n = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("rpt_edge%0d", i), pulse_q[i], exp_q[i]);

    // Held bit 1: never repeats
    do_reset();
    buttons_raw = 2'b10;
    pulse_q.delete();
    p0 = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (buttons_re[1]) pulse_q.push_back(k);
      if (buttons_re[0]) p0++;
      if (k == 40) buttons_raw = 2'b00;
    end
    chk("mask_count", pulse_q.size(), 1);
    if (pulse_q.size() > 0) chk("mask_edge", pulse_q[0], 6);
    chk("mask_bit0", p0, 0);

    // Randomized activity against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk("rand_lvl", {30'd0, buttons_level}, {30'd0, m_lvl});
      chk("rand_re", {30'd0, buttons_re}, {30'd0, m_re});
      if (!async_nreset) async_nreset = 1'b1;
      else if ($urandom % 600 == 0) async_nreset = 1'b0;
      flip = ($urandom % 12 == 0) ? (2'b01 << ($urandom % 2)) : 2'b00;
      buttons_raw = buttons_raw ^ flip;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
